// File: rtl/cmos_dvp_rx_v2.sv
// DVP sensor bus receiver: assembles BPP bus words per pixel, adds SOF/EOL, skips warm-up frames.
// Define CMOS_STATS_EN to enable measured frame width/height outputs (tied to 0 otherwise).
module cmos_dvp_rx_v2 #(
  parameter int DATA_W         = 8,
  parameter int BPP            = 2,
  parameter int FRAME_WAIT     = 15,
  parameter int MSB_FIRST      = 1,
  parameter int VS_ACTIVE_HIGH = 1,
  parameter int CNT_W          = 12
) (
  input  logic                    cmos_pclk_i,
  input  logic                    rst_n_i,
  input  logic                    cmos_href_i,
  input  logic                    cmos_vsync_i,
  input  logic [DATA_W-1:0]       cmos_data_i,
  input  logic                    enable_i,
  output logic                    pix_valid_o,
  output logic [DATA_W*BPP-1:0]   pix_data_o,
  output logic                    sof_o,
  output logic                    eol_o,
  output logic                    out_en_o,
  output logic [7:0]              frame_cnt_o,
  output logic                    line_err_o,
  output logic                    byte_err_o,
  output logic [CNT_W-1:0]        frame_w_o,
  output logic [CNT_W-1:0]        frame_h_o
);
  localparam int PW = DATA_W * BPP;
  localparam logic [7:0] FW8 = 8'(FRAME_WAIT);
  localparam logic [1:0] WLAST = 2'(BPP - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_IDLE, ST_ACTIVE} state_t;

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  state_t            state_q, state_d;
  logic              href1_q, href1_d, href2_q, href2_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [1:0]        vld_q, vld_d;
  logic [7:0]        warm_q, warm_d, frame_cnt_q, frame_cnt_d;
  logic              out_en_q, out_en_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [PW-1:0]     asm_q, asm_d, hold_q, hold_d, pix_data_q, pix_data_d, asm_shift;
  logic              hold_vld_q, hold_vld_d, sof_pend_q, sof_pend_d;
  logic [CNT_W-1:0]  line_px_q, line_px_d, ref_w_q, ref_w_d;
  logic              ref_vld_q, ref_vld_d;
  logic              pix_valid_q, pix_valid_d, sof_q, sof_d, eol_q, eol_d;
  logic              line_err_q, line_err_d, byte_err_q, byte_err_d;
  logic              frame_start, frame_end, href_fall;

  generate
    if (BPP == 1) begin : g_one
      assign asm_shift = data1_q;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign asm_shift = {asm_q[PW-DATA_W-1:0], data1_q};
    end else begin : g_lsb
      assign asm_shift = {data1_q, asm_q[PW-1:DATA_W]};
    end
  endgenerate

  // Edges are only trusted once both stage copies hold real samples, so an idle-blanking
  // VSYNC at reset release is not mistaken for a frame end.
  assign frame_start = vld_q[1] &  vs2_q   & ~vs1_q;
  assign frame_end   = vld_q[1] & ~vs2_q   &  vs1_q;
  assign href_fall   = vld_q[1] &  href2_q & ~href1_q;

  always_comb begin
    vld_d       = {vld_q[0], 1'b1};
    href1_d     = cmos_href_i;
    vs1_d       = (VS_ACTIVE_HIGH != 0) ? cmos_vsync_i : ~cmos_vsync_i;
    data1_d     = cmos_data_i;
    href2_d     = href1_q;
    vs2_d       = vs1_q;
    warm_d      = warm_q;
    if (frame_start && warm_q != FW8) warm_d = warm_q + 8'd1;
    out_en_d    = (warm_q == FW8);
    frame_cnt_d = frame_cnt_q + {7'd0, frame_end};
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    asm_d       = asm_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    sof_pend_d  = sof_pend_q;
    line_px_d   = line_px_q;
    ref_w_d     = ref_w_q;
    ref_vld_d   = ref_vld_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    line_err_d  = 1'b0;
    byte_err_d  = 1'b0;

    case (state_q)
      ST_WAIT:   if (out_en_q) state_d = ST_IDLE;
      ST_IDLE:   if (frame_start && enable_i) state_d = ST_ACTIVE;
      ST_ACTIVE: if (frame_end) state_d = ST_IDLE;
      default:   state_d = ST_WAIT;
    endcase

    if (state_q == ST_ACTIVE && !frame_start) begin
      if (href1_q) begin
        asm_d = asm_shift;
        if (wcnt_q == WLAST) begin
          wcnt_d     = 2'd0;
          hold_d     = asm_shift;
          hold_vld_d = 1'b1;
          line_px_d  = line_px_q + CNT_W'(1);
          if (hold_vld_q) begin
            pix_valid_d = 1'b1;
            pix_data_d  = hold_q;
            sof_d       = sof_pend_q;
            sof_pend_d  = 1'b0;
          end
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end else if (href_fall) begin
        wcnt_d     = 2'd0;
        byte_err_d = (wcnt_q != 2'd0);
        if (hold_vld_q) begin
          pix_valid_d = 1'b1;
          pix_data_d  = hold_q;
          sof_d       = sof_pend_q;
          sof_pend_d  = 1'b0;
          eol_d       = 1'b1;
          hold_vld_d  = 1'b0;
          line_px_d   = '0;
          if (ref_vld_q) begin
            line_err_d = (line_px_q != ref_w_q);
          end else begin
            ref_w_d   = line_px_q;
            ref_vld_d = 1'b1;
          end
        end
      end
    end

    // Outside capture, or on a (re)started frame, any partial line state is discarded.
    if (state_q != ST_ACTIVE || frame_start) begin
      wcnt_d     = 2'd0;
      hold_vld_d = 1'b0;
      line_px_d  = '0;
    end
    if (frame_start) begin
      ref_w_d    = '0;
      ref_vld_d  = 1'b0;
      sof_pend_d = 1'b1;
    end
  end

  always_ff @(posedge cmos_pclk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_WAIT;
      href1_q     <= 1'b0;
      href2_q     <= 1'b0;
      vs1_q       <= 1'b0;
      vs2_q       <= 1'b0;
      data1_q     <= '0;
      vld_q       <= '0;
      warm_q      <= '0;
      frame_cnt_q <= '0;
      out_en_q    <= 1'b0;
      wcnt_q      <= '0;
      asm_q       <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      sof_pend_q  <= 1'b0;
      line_px_q   <= '0;
      ref_w_q     <= '0;
      ref_vld_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      line_err_q  <= 1'b0;
      byte_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      href1_q     <= href1_d;
      href2_q     <= href2_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      data1_q     <= data1_d;
      vld_q       <= vld_d;
      warm_q      <= warm_d;
      frame_cnt_q <= frame_cnt_d;
      out_en_q    <= out_en_d;
      wcnt_q      <= wcnt_d;
      asm_q       <= asm_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      sof_pend_q  <= sof_pend_d;
      line_px_q   <= line_px_d;
      ref_w_q     <= ref_w_d;
      ref_vld_q   <= ref_vld_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      line_err_q  <= line_err_d;
      byte_err_q  <= byte_err_d;
    end
  end

`ifdef CMOS_STATS_EN
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d, frame_w_q, frame_w_d, frame_h_q, frame_h_d;

  always_comb begin
    line_cnt_d = line_cnt_q;
    frame_w_d  = frame_w_q;
    frame_h_d  = frame_h_q;
    if (eol_d) line_cnt_d = line_cnt_q + CNT_W'(1);
    if (frame_start) line_cnt_d = '0;
    if (frame_end && state_q == ST_ACTIVE) begin
      frame_w_d = ref_w_q;
      frame_h_d = line_cnt_q;
    end
  end

  always_ff @(posedge cmos_pclk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      line_cnt_q <= '0;
      frame_w_q  <= '0;
      frame_h_q  <= '0;
    end else begin
      line_cnt_q <= line_cnt_d;
      frame_w_q  <= frame_w_d;
      frame_h_q  <= frame_h_d;
    end
  end

  assign frame_w_o = frame_w_q;
  assign frame_h_o = frame_h_q;
`else
  assign frame_w_o = '0;
  assign frame_h_o = '0;
`endif

  assign pix_valid_o = pix_valid_q;
  assign pix_data_o  = pix_data_q;
  assign sof_o       = sof_q;
  assign eol_o       = eol_q;
  assign out_en_o    = out_en_q;
  assign frame_cnt_o = frame_cnt_q;
  assign line_err_o  = line_err_q;
  assign byte_err_o  = byte_err_q;

endmodule

// File: tb/tb_cmos_dvp_rx_v2.sv
// Randomised bench for cmos_dvp_rx_v2: two instances (MSB-first/high VSYNC and LSB-first/low VSYNC)
// driven from one sensor stream and checked against a frame/line level model.
module tb_cmos_dvp_rx_v2;
  localparam int DW = 8, BPP = 2, FW = 2, CW = 12, PW = DW * BPP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, href, vsync, en;
  logic          vsync_n;
  logic [DW-1:0] data;
  assign vsync_n = ~vsync;

  logic          a_valid, a_sof, a_eol, a_out_en, a_lerr, a_berr;
  logic [PW-1:0] a_data;
  logic [7:0]    a_fcnt;
  logic [CW-1:0] a_fw, a_fh;
  logic          b_valid, b_sof, b_eol, b_out_en, b_lerr, b_berr;
  logic [PW-1:0] b_data;
  logic [7:0]    b_fcnt;
  logic [CW-1:0] b_fw, b_fh;

  cmos_dvp_rx_v2 #(.DATA_W(DW), .BPP(BPP), .FRAME_WAIT(FW), .MSB_FIRST(1),
                   .VS_ACTIVE_HIGH(1), .CNT_W(CW)) dut_a (
    .cmos_pclk_i(clk), .rst_n_i(rst_n), .cmos_href_i(href), .cmos_vsync_i(vsync),
    .cmos_data_i(data), .enable_i(en), .pix_valid_o(a_valid), .pix_data_o(a_data),
    .sof_o(a_sof), .eol_o(a_eol), .out_en_o(a_out_en), .frame_cnt_o(a_fcnt),
    .line_err_o(a_lerr), .byte_err_o(a_berr), .frame_w_o(a_fw), .frame_h_o(a_fh));

  cmos_dvp_rx_v2 #(.DATA_W(DW), .BPP(BPP), .FRAME_WAIT(FW), .MSB_FIRST(0),
                   .VS_ACTIVE_HIGH(0), .CNT_W(CW)) dut_b (
    .cmos_pclk_i(clk), .rst_n_i(rst_n), .cmos_href_i(href), .cmos_vsync_i(vsync_n),
    .cmos_data_i(data), .enable_i(en), .pix_valid_o(b_valid), .pix_data_o(b_data),
    .sof_o(b_sof), .eol_o(b_eol), .out_en_o(b_out_en), .frame_cnt_o(b_fcnt),
    .line_err_o(b_lerr), .byte_err_o(b_berr), .frame_w_o(b_fw), .frame_h_o(b_fh));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [PW-1:0] da;
    logic [PW-1:0] db;
    bit            sof;
    bit            eol;
    bit            lerr;
  } pix_t;

  pix_t exp_q[$];
  int starts = 0, fends = 0, exp_berr = 0, exp_lerr = 0, exp_w = 0, exp_h = 0;
  int obs_lerr_a = 0, obs_berr_a = 0, obs_lerr_b = 0, obs_berr_b = 0, npix = 0;

  always @(negedge clk) begin : mon
    pix_t e;
    if (a_lerr) obs_lerr_a++;
    if (a_berr) obs_berr_a++;
    if (b_lerr) obs_lerr_b++;
    if (b_berr) obs_berr_b++;
    if (a_valid || b_valid) begin
      if (exp_q.size() == 0) begin
        chk("pix_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("a_valid", 32'(a_valid), 32'd1);
        chk("b_valid", 32'(b_valid), 32'd1);
        chk("a_data", 32'(a_data), 32'(e.da));
        chk("b_data", 32'(b_data), 32'(e.db));
        chk("a_sof", 32'(a_sof), 32'(e.sof));
        chk("b_sof", 32'(b_sof), 32'(e.sof));
        chk("a_eol", 32'(a_eol), 32'(e.eol));
        chk("b_eol", 32'(b_eol), 32'(e.eol));
        chk("a_lerr", 32'(a_lerr), 32'(e.lerr));
        chk("b_lerr", 32'(b_lerr), 32'(e.lerr));
        $display("PIX %0d a=%h b=%h sof=%0b eol=%0b lerr=%0b", npix, a_data, b_data,
                 a_sof, a_eol, a_lerr);
        npix++;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(a_valid), 32'd0);
    chk({tag, "_data"}, 32'(a_data), 32'd0);
    chk({tag, "_sof"}, 32'(a_sof), 32'd0);
    chk({tag, "_eol"}, 32'(a_eol), 32'd0);
    chk({tag, "_out_en"}, 32'(a_out_en), 32'd0);
    chk({tag, "_fcnt"}, 32'(a_fcnt), 32'd0);
    chk({tag, "_lerr"}, 32'(a_lerr), 32'd0);
    chk({tag, "_berr"}, 32'(a_berr), 32'd0);
    chk({tag, "_fw"}, 32'(a_fw), 32'd0);
    chk({tag, "_fh"}, 32'(a_fh), 32'd0);
    chk({tag, "_b_data"}, 32'(b_data), 32'd0);
    chk({tag, "_b_out_en"}, 32'(b_out_en), 32'd0);
  endtask

  // One frame: blanking, frame start, nl lines of wl[] words, frame end; model built per line.
  task automatic run_frame(input int nl, input int wl[8], input int en_mid);
    bit         cap, ref_ok, first;
    int         ref_w, nlines, np;
    logic [7:0] w[$];
    pix_t       p;
    repeat (6) @(negedge clk);
    chk("out_en_a", 32'(a_out_en), 32'(starts >= FW));
    chk("out_en_b", 32'(b_out_en), 32'(starts >= FW));
    cap = (starts >= FW) && en;
    starts++;
    vsync = 1'b0;
    repeat (5) @(negedge clk);
    ref_ok = 1'b0; ref_w = 0; nlines = 0; first = 1'b1;
    for (int l = 0; l < nl; l++) begin
      w.delete();
      for (int k = 0; k < wl[l]; k++) w.push_back(8'($urandom));
      np = wl[l] / BPP;
      if (cap) begin
        for (int i = 0; i < np; i++) begin
          p.da   = {w[2*i], w[2*i+1]};
          p.db   = {w[2*i+1], w[2*i]};
          p.sof  = first;
          first  = 1'b0;
          p.eol  = (i == np - 1);
          p.lerr = (i == np - 1) && ref_ok && (np != ref_w);
          exp_q.push_back(p);
        end
        if (np > 0) begin
          nlines++;
          if (ref_ok && np != ref_w) exp_lerr++;
          if (!ref_ok) begin ref_ok = 1'b1; ref_w = np; end
        end
        if (wl[l] % BPP != 0) exp_berr++;
      end
      for (int k = 0; k < wl[l]; k++) begin
        href = 1'b1;
        data = w[k];
        @(negedge clk);
      end
      href = 1'b0;
      data = 8'($urandom);
      repeat (6) @(negedge clk);
      if (l == 0 && en_mid >= 0) en = (en_mid != 0);
    end
    vsync = 1'b1;
    fends++;
    repeat (5) @(negedge clk);
    if (cap) begin exp_w = ref_w; exp_h = nlines; end
    chk("fcnt_a", 32'(a_fcnt), 32'(fends % 256));
    chk("fcnt_b", 32'(b_fcnt), 32'(fends % 256));
    chk("berr_a", 32'(obs_berr_a), 32'(exp_berr));
    chk("berr_b", 32'(obs_berr_b), 32'(exp_berr));
    chk("lerr_a", 32'(obs_lerr_a), 32'(exp_lerr));
    chk("lerr_b", 32'(obs_lerr_b), 32'(exp_lerr));
`ifdef CMOS_STATS_EN
    chk("fw_a", 32'(a_fw), 32'(exp_w));
    chk("fh_a", 32'(a_fh), 32'(exp_h));
    chk("fw_b", 32'(b_fw), 32'(exp_w));
    chk("fh_b", 32'(b_fh), 32'(exp_h));
`else
    chk("fw_a", 32'(a_fw), 32'd0);
    chk("fh_a", 32'(a_fh), 32'd0);
`endif
    $display("FRAME %0d cap=%0b lines=%0d w=%0d h=%0d", fends, cap, nl, exp_w, exp_h);
  endtask

  task automatic rand_frame(input int en_mid);
    int wl[8];
    for (int i = 0; i < 8; i++) wl[i] = $urandom_range(1, 20);
    run_frame($urandom_range(1, 5), wl, en_mid);
  endtask

  initial begin
    rst_n = 1'b0; href = 1'b0; vsync = 1'b1; en = 1'b1; data = '0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    rand_frame(-1);
    rand_frame(-1);
    run_frame(4, '{16, 16, 16, 16, 0, 0, 0, 0}, -1);
    run_frame(4, '{16, 16, 16, 16, 0, 0, 0, 0}, -1);
    run_frame(3, '{16, 16, 12, 0, 0, 0, 0, 0}, -1);
    run_frame(3, '{16, 15, 16, 0, 0, 0, 0, 0}, -1);
    rand_frame(0);
    rand_frame(1);
    for (int f = 0; f < 6; f++) rand_frame(-1);

    // Uncaptured frame interrupted by reset in the middle of a line.
    chk("out_en_pre_rst", 32'(a_out_en), 32'd1);
    en = 1'b0;
    repeat (6) @(negedge clk);
    vsync = 1'b0;
    repeat (5) @(negedge clk);
    href = 1'b1;
    repeat (5) begin data = 8'($urandom); @(negedge clk); end
    #3 rst_n = 1'b0;
    #1 check_zero("midline");
    exp_q.delete();
    starts = 0; fends = 0; exp_berr = 0; exp_lerr = 0; exp_w = 0; exp_h = 0;
    obs_berr_a = 0; obs_berr_b = 0; obs_lerr_a = 0; obs_lerr_b = 0;
    @(negedge clk);
    href = 1'b0; vsync = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rand_frame(-1);
    rand_frame(-1);
    run_frame(4, '{16, 16, 16, 16, 0, 0, 0, 0}, -1);

    repeat (20) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmos_dvp_rx_v2.md
Name: cmos_dvp_rx_v2

Overview:
Parametrised successor to the first-generation DVP capture decoder. Takes a raw sensor parallel bus (pixel clock, HREF, VSYNC, N-bit data) and assembles 1-3 bus words per pixel into a pixel-valid stream with start-of-frame and end-of-line flags. Skips a programmable number of warm-up frames and measures line length, flagging malformed lines and partial pixels. Sits between the sensor pins and the video-in/DMA bridge.

Parameters:
DATA_W, 8, sensor bus width (8 or 10).
BPP, 2, bus words per pixel (1..3); pix_data_o width = DATA_W*BPP.
FRAME_WAIT, 15, frames discarded after reset before output is enabled (0..255).
MSB_FIRST, 1, 1 = first word lands in the top of pix_data_o; 0 = first word lands in the bottom.
VS_ACTIVE_HIGH, 1, 1 = VSYNC high during vertical blanking; 0 = inverted.
CNT_W, 12, width of the pixel and line counters.

Ports:
cmos_pclk_i  in  1  sensor pixel clock; the only clock.
rst_n_i  in  1  asynchronous active-low reset.
cmos_href_i  in  1  line-valid from sensor.
cmos_vsync_i  in  1  frame sync from sensor.
cmos_data_i  in  DATA_W  sensor data.
enable_i  in  1  capture enable; sampled only at frame start.
pix_valid_o  out  1  one-cycle pixel strobe.
pix_data_o  out  DATA_W*BPP  assembled pixel.
sof_o  out  1  with the first pixel of a frame.
eol_o  out  1  with the last pixel of a line.
out_en_o  out  1  warm-up complete.
frame_cnt_o  out  8  frames completed since reset, wraps at 255.
line_err_o  out  1  one-cycle pulse: line pixel count differs from the frame's first line.
byte_err_o  out  1  one-cycle pulse: HREF fell with a partial pixel.
frame_w_o  out  CNT_W  measured width (optional feature).
frame_h_o  out  CNT_W  measured height (optional feature).

Behaviour:
- Reset asynchronously clears all state; every output is 0. Release is synchronised with a 2-flop chain on cmos_pclk_i.
- Stage 1 registers href, vsync (normalised to active-high blanking) and data. All logic uses the stage-1 copies.
- Frame start is the vsync inactive edge; frame end is the vsync active edge.
- Warm-up counter increments at each frame start and saturates at FRAME_WAIT. out_en_o rises the cycle after the count reaches FRAME_WAIT. With FRAME_WAIT=0, out_en_o rises one cycle after reset release.
- frame_cnt_o increments at each frame end, regardless of out_en_o.
- FSM states:
  - WAIT: out_en_o=0. Go to IDLE when out_en_o rises.
  - IDLE: go to ACTIVE at a frame start if enable_i=1; otherwise stay.
  - ACTIVE: capture. Go to IDLE at frame end.
- A frame start seen while in ACTIVE (missed vsync edge) restarts the frame. The held pixel is discarded and first-line width is re-latched.
- Word assembly runs only in ACTIVE with href=1:
  - Word counter runs 0..BPP-1; each word shifts into the assembly register.
  - At count BPP-1 the completed pixel moves to a one-pixel hold register and the counter wraps to 0.
  - Placement follows MSB_FIRST.
- Output from the hold register:
  - When the next pixel completes, the held pixel is emitted with eol_o=0.
  - When href falls, the held pixel is emitted with eol_o=1.
  - pix_valid_o, pix_data_o, sof_o and eol_o are registered. pix_data_o holds its value between strobes.
- sof_o is 1 on the first emitted pixel after a frame start.
- If href falls with word counter ≠0, the partial words are dropped, byte_err_o pulses and the counter clears. A complete held pixel is still emitted with eol_o.
- Pixel-per-line counter: the first line of the frame latches the reference width. On each later line's eol, a mismatch pulses line_err_o in the same cycle as eol_o.
- A line with zero complete pixels emits nothing and is not counted.

Optional Feature:
CMOS_STATS_EN:
- Defined: a line counter counts lines with eol. At each frame end in ACTIVE, frame_w_o latches the first-line width and frame_h_o latches the line count. Both hold until the next frame end.
- Undefined: no counters; frame_w_o and frame_h_o are tied to 0.

Test Plan:
1. FRAME_WAIT=2, 4 frames of 4 lines x 8 px (16 words/line, BPP=2) -> out_en_o after 2nd frame start; frames 3-4 each give 32 pix_valid_o, one sof_o, four eol_o; frame_cnt_o=4.
2. MSB_FIRST=1, words 0xAB,0xCD -> pix_data_o=0xABCD; MSB_FIRST=0 -> 0xCDAB.
3. Line of 15 words (BPP=2) -> 7 pixels, last with eol_o, byte_err_o pulse.
4. Frame lines of 8,8,6 px -> line_err_o exactly once, coincident with the third eol_o.
5. enable_i dropped mid-frame -> current frame completes; the next frame is not captured; re-raising enable_i resumes capture at the following frame start.
6. rst_n_i asserted mid-line -> all outputs 0 immediately; after release, out_en_o waits the full FRAME_WAIT again; CMOS_STATS_EN build reports frame_w_o=8, frame_h_o=4 for the case-1 frame.
